// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the conv layer stream controllers: FSM encoding and
// the derived beat counts of a convolution layer.
package cnn_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadW = 3'd1,
        StLoadP = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } ctrl_state_e;

    function automatic int unsigned weight_num(input int unsigned cin, input int unsigned cout,
                                               input int unsigned kernel);
        return cin * cout * kernel * kernel;
    endfunction

    function automatic int unsigned pixel_num(input int unsigned cin, input int unsigned width,
                                              input int unsigned height);
        return cin * width * height;
    endfunction

    // Valid (unpadded) convolution: one output per kernel position per output channel.
    function automatic int unsigned out_num(input int unsigned width, input int unsigned height,
                                            input int unsigned kernel, input int unsigned cout);
        return (width - kernel + 1) * (height - kernel + 1) * cout;
    endfunction

endpackage

// File: rtl/cnn_beat_counter.sv
// Up-counter with clear, enable and a terminal-count compare; saturates at MAX_COUNT.
module cnn_beat_counter #(
    parameter int unsigned MAX_COUNT = 255,
    localparam int unsigned WIDTH = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && count != WIDTH'(MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/cnn_conv_stream_ctrl.sv
// Streams weights then pixels from a synchronous-read buffer into one conv layer and
// counts its outputs, finishing with done (or done+error on a drain timeout).
module cnn_conv_stream_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 24,
    parameter int unsigned IMAGE_WIDTH     = 1224,
    parameter int unsigned IMAGE_HEIGHT    = 1224,
    parameter int unsigned CHANNEL_NUM_IN  = 3,
    parameter int unsigned CHANNEL_NUM_OUT = 64,
    parameter int unsigned KERNEL          = 7,
    parameter int unsigned OUT_NUM         = out_num(IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL,
                                                     CHANNEL_NUM_OUT),
    parameter int unsigned WEIGHT_BASE     = 0,
    parameter int unsigned PIXEL_BASE      = 'h10000,
    parameter int unsigned TIMEOUT         = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid_weight_in,
    output logic [DATA_WIDTH-1:0] weight_in,
    output logic                  valid_in,
    output logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WEIGHT_NUM = weight_num(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
    localparam int unsigned PIXEL_NUM  = pixel_num(CHANNEL_NUM_IN, IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int unsigned ISSUE_MAX  = (WEIGHT_NUM > PIXEL_NUM) ? WEIGHT_NUM : PIXEL_NUM;
    localparam int unsigned ISSUE_W    = $clog2(ISSUE_MAX + 1);
    localparam int unsigned OUT_W      = $clog2(OUT_NUM + 1);
    localparam int unsigned IDLE_W     = $clog2(TIMEOUT + 1);
    localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_WIDTH;

    if ((64'(WEIGHT_BASE) + 64'(WEIGHT_NUM) > ADDR_SPAN) ||
        (64'(PIXEL_BASE) + 64'(PIXEL_NUM) > ADDR_SPAN)) begin : g_addr_check
        $error("cnn_conv_stream_ctrl: buffer region exceeds ADDR_WIDTH");
    end

    ctrl_state_e state_q, state_d;
    logic        fwd_valid_q, fwd_pixel_q;
    logic        err_q, err_d;

    logic                  start_ok, issue, issue_last, out_hit, idle_hit;
    logic [ISSUE_W-1:0]    issue_cnt, issue_term;
    logic [OUT_W-1:0]      out_cnt_unused;
    logic [IDLE_W-1:0]     idle_cnt_unused;
    logic [ADDR_WIDTH-1:0] base_addr;

    assign start_ok   = (state_q == StIdle) && start;
    assign issue      = ((state_q == StLoadW) || (state_q == StLoadP)) && !stall;
    assign issue_term = (state_q == StLoadP) ? ISSUE_W'(PIXEL_NUM - 1) : ISSUE_W'(WEIGHT_NUM - 1);

    // Cleared on the last issue of each phase so the pixel phase starts at index 0.
    cnn_beat_counter #(.MAX_COUNT(ISSUE_MAX)) u_issue_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok || (issue && issue_last)),
        .en    (issue),
        .term  (issue_term),
        .count (issue_cnt),
        .tc    (issue_last)
    );

    cnn_beat_counter #(.MAX_COUNT(OUT_NUM)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .en    (valid_out && ((state_q == StLoadP) || (state_q == StDrain))),
        .term  (OUT_W'(OUT_NUM)),
        .count (out_cnt_unused),
        .tc    (out_hit)
    );

    cnn_beat_counter #(.MAX_COUNT(TIMEOUT)) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (valid_out || (state_q != StDrain)),
        .en    (1'b1),
        .term  (IDLE_W'(TIMEOUT)),
        .count (idle_cnt_unused),
        .tc    (idle_hit)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadW;
                    err_d   = 1'b0;
                end
            end
            StLoadW: if (issue && issue_last) state_d = StLoadP;
            StLoadP: if (issue && issue_last) state_d = StDrain;
            StDrain: begin
                if (out_hit) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                end else if (idle_hit) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_pixel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            fwd_valid_q <= issue;
            fwd_pixel_q <= (state_q == StLoadP);
        end
    end

    always_comb begin
        base_addr       = (state_q == StLoadP) ? ADDR_WIDTH'(PIXEL_BASE) : ADDR_WIDTH'(WEIGHT_BASE);
        rd_en           = issue;
        rd_addr         = issue ? base_addr + ADDR_WIDTH'(issue_cnt) : '0;
        valid_weight_in = fwd_valid_q && !fwd_pixel_q;
        valid_in        = fwd_valid_q && fwd_pixel_q;
        weight_in       = valid_weight_in ? rd_data : '0;
        pxl_in          = valid_in ? rd_data : '0;
        busy            = (state_q == StLoadW) || (state_q == StLoadP) || (state_q == StDrain);
        done            = (state_q == StDone);
        error           = (state_q == StDone) && err_q;
    end

endmodule

// File: tb/tb_cnn_conv_stream_ctrl.sv
// Randomized bench: scoreboard queues of expected weight/pixel words, a buffer model
// returning its address as data, and a conv model emitting valid_out beats.
module tb_cnn_conv_stream_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 24;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int CIN  = 1;
    localparam int COUT = 2;
    localparam int K    = 3;
    localparam int TMO  = 20;
    localparam int WB   = 0;
    localparam int PB   = 'h10000;
    localparam int WN   = CIN * COUT * K * K;
    localparam int PN   = CIN * IW * IH;
    localparam int ON   = (IW - K + 1) * (IH - K + 1) * COUT;

    logic          clk = 1'b0;
    logic          reset, start, stall, valid_out;
    logic          rd_en, valid_weight_in, valid_in, busy, done, error;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, weight_in, pxl_in;

    cnn_conv_stream_ctrl #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .IMAGE_WIDTH     (IW),
        .IMAGE_HEIGHT    (IH),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT),
        .KERNEL          (K),
        .WEIGHT_BASE     (WB),
        .PIXEL_BASE      (PB),
        .TIMEOUT         (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .valid_weight_in (valid_weight_in),
        .weight_in       (weight_in),
        .valid_in        (valid_in),
        .pxl_in          (pxl_in),
        .valid_out       (valid_out),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer: data equals address, one cycle after the read; junk when not read.
    always @(posedge clk) rd_data <= rd_en ? DW'(rd_addr) : 32'hdead_beef;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    longint wq[$];
    longint pq[$];
    int vw_seen, vi_seen, first_w, last_w, first_vi, last_vi;
    int n_done, done_cyc, done_err;
    int beats_left = 0, last_beat, gap;

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        longint exp_v;
        if (!reset) begin
            if (valid_weight_in || valid_in) chk("both_strobes", 64'(valid_weight_in && valid_in), 0);
            if (valid_weight_in) begin
                exp_v = (wq.size() > 0) ? wq.pop_front() : -1;
                chk("weight_in", weight_in, exp_v);
                if (vw_seen == 0) first_w = cyc;
                last_w = cyc;
                vw_seen++;
            end else begin
                chk("weight_in_quiet", weight_in, 0);
            end
            if (valid_in) begin
                chk("pixel_before_weights_done", wq.size(), 0);
                exp_v = (pq.size() > 0) ? pq.pop_front() : -1;
                chk("pxl_in", pxl_in, exp_v);
                if (vi_seen == 0) first_vi = cyc;
                last_vi = cyc;
                vi_seen++;
            end else begin
                chk("pxl_in_quiet", pxl_in, 0);
            end
            if (rd_en) chk("rd_en_while_busy", 64'(busy), 1);
            if (error) chk("error_without_done", 64'(done), 1);
            if (done) begin
                n_done++;
                done_cyc = cyc;
                done_err = int'(error);
            end
        end
    end

    // Conv model: random valid_out beats once the pixel phase is well under way.
    initial begin
        valid_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (beats_left > 0 && vi_seen >= 40 && (gap >= 4 || $urandom_range(0, 3) != 0)) begin
                valid_out = 1'b1;
                beats_left--;
                last_beat = cyc;
                gap = 0;
            end else begin
                valid_out = 1'b0;
                if (beats_left > 0 && vi_seen >= 40) gap++;
            end
        end
    end

    task automatic begin_layer(input int beats);
        wq.delete();
        pq.delete();
        for (int i = 0; i < WN; i++) wq.push_back(longint'(WB + i));
        for (int i = 0; i < PN; i++) pq.push_back(longint'(PB + i));
        vw_seen = 0; vi_seen = 0; first_w = -1; last_w = -1; first_vi = -1; last_vi = -1;
        n_done = 0; done_cyc = -1; done_err = -1; last_beat = -1; gap = 0;
        beats_left = beats;
    endtask

    task automatic run_layer(input bit with_stall, input int beats, input bit poke);
        int start_cyc, rel, exp_done, stall_cycles;
        bit poked;
        begin_layer(beats);
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        poked = 1'b0;
        for (int n = 0; n < 3000 && n_done == 0; n++) begin
            @(posedge clk);
            #1;
            rel   = cyc - start_cyc - 1;
            start = poke && !poked && vi_seen == 10;
            if (start) poked = 1'b1;
            stall = with_stall && ((rel >= 5 && rel <= 9) || (rel >= 23 && rel <= 27));
        end
        start = 1'b0;
        stall = 1'b0;
        stall_cycles = with_stall ? 10 : 0;
        chk("done_seen", n_done, 1);
        chk("weight_count", vw_seen, WN);
        chk("pixel_count", vi_seen, PN);
        chk("weights_left", wq.size(), 0);
        chk("pixels_left", pq.size(), 0);
        chk("first_weight_latency", first_w - start_cyc, 2);
        chk("w_to_p_gap", first_vi - last_w, with_stall ? 6 : 1);
        if (!with_stall) chk("first_pixel_after_first_weight", first_vi - first_w, WN);
        chk("stream_span", last_vi - first_w, WN + PN - 1 + stall_cycles);
        if (beats >= ON)
            exp_done = (last_beat + 2 > last_vi + 1) ? last_beat + 2 : last_vi + 1;
        else
            exp_done = ((last_beat + 1 > last_vi) ? last_beat + 1 : last_vi) + TMO + 1;
        chk("done_cycle", done_cyc, exp_done);
        chk("done_error_flag", done_err, (beats < ON) ? 1 : 0);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 0);
        repeat (6) @(negedge clk);
        chk("single_done", n_done, 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rd_en, valid_weight_in, valid_in, busy, done, error,
                              rd_addr, weight_in, pxl_in}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_layer(1'b0, ON, 1'b0);
        run_layer(1'b1, ON, 1'b0);
        run_layer(1'b0, ON, 1'b1);
        run_layer(1'b0, ON - 1, 1'b0);

        // Reset in the middle of the pixel stream, then a clean replay.
        begin_layer(0);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 500 && vi_seen < 30; n++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_pixel_30", vi_seen, 30);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midop_reset_outputs", {rd_en, valid_weight_in, valid_in, busy, done, error,
                                    rd_addr, weight_in, pxl_in}, 0);
        repeat (3) @(negedge clk);
        chk("stays_idle_after_reset", 64'(busy), 0);
        run_layer(1'b0, ON, 1'b0);

        // start together with reset must not launch a layer.
        n_done = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("start_with_reset_busy", 64'(busy), 0);
        chk("start_with_reset_rd_en", 64'(rd_en), 0);
        repeat (4) @(negedge clk);
        chk("start_with_reset_no_stream", vw_seen + vi_seen + n_done, WN + PN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
